// File: rtl/int_to_float_pkg.sv
// int_to_float_pkg: shared float state encodings and IEEE-754 single constants
package int_to_float_pkg;
  localparam logic [2:0] GET_A     = 3'd0;
  localparam logic [2:0] CONVERT   = 3'd1;
  localparam logic [2:0] NORMALISE = 3'd2;
  localparam logic [2:0] ROUND     = 3'd3;
  localparam logic [2:0] PACK      = 3'd4;
  localparam logic [2:0] PUT_Z     = 3'd5;
  localparam int FLOAT_EXP_BIAS = 127;
  localparam int FLOAT_MANT_W   = 23;
  localparam int FLOAT_EXP_W    = 8;
  localparam logic [31:0] FLOAT_ZERO = 32'h0;
endpackage

// File: rtl/int_to_float.sv
// int_to_float: iterative 32-bit integer to IEEE-754 single converter with stb/ack handshakes
module int_to_float
  import int_to_float_pkg::*;
#(
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_a,
  input  logic        in_a_stb,
  output logic        in_a_ack,
  output logic [31:0] out_z,
  output logic        out_z_stb,
  input  logic        out_z_ack
);
  logic [2:0] state;
  logic [31:0] a, m, mag;
  logic sign, neg, up;
  logic signed [9:0] e;
  logic [FLOAT_EXP_W-1:0] e_biased;
  always_comb begin
    neg = SIGNED_IN && a[31];
    mag = neg ? 32'(-a) : a;
    up = m[7] & (m[6] | (|m[5:0]) | m[8]);
    e_biased = FLOAT_EXP_W'(e + 10'(FLOAT_EXP_BIAS));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GET_A;
      in_a_ack <= 1'b0;
      out_z_stb <= 1'b0;
      out_z <= FLOAT_ZERO;
      a <= '0;
      m <= '0;
      e <= '0;
      sign <= 1'b0;
    end else begin
      case (state)
        GET_A: begin
          in_a_ack <= 1'b1;
          if (in_a_stb && in_a_ack) begin
            a <= in_a;
            in_a_ack <= 1'b0;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          if (a == '0) begin
            out_z <= FLOAT_ZERO;
            sign <= 1'b0;
            out_z_stb <= 1'b1;
            state <= PUT_Z;
          end else begin
            sign <= neg;
            m <= mag;
            e <= 10'sd31;
            state <= NORMALISE;
          end
        end
        NORMALISE: begin
          if (!m[31]) begin
            m <= m << 1;
            e <= e - 10'sd1;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          if (up) begin
            if (&m[31:8]) begin
              m[31:8] <= 24'h800000;
              e <= e + 10'sd1;
            end else begin
              m[31:8] <= m[31:8] + 24'd1;
            end
          end
          state <= PACK;
        end
        PACK: begin
          out_z <= {sign, e_biased, m[30 -: FLOAT_MANT_W]};
          out_z_stb <= 1'b1;
          state <= PUT_Z;
        end
        PUT_Z: begin
          if (out_z_ack) begin
            out_z_stb <= 1'b0;
            in_a_ack <= 1'b1;
            state <= GET_A;
          end
        end
        default: state <= GET_A;
      endcase
    end
  end
endmodule

// File: tb/tb_int_to_float.sv
// tb_int_to_float: table-driven and sequence checks for signed and unsigned int_to_float
module tb_int_to_float;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] s_a = '0, u_a = '0;
  logic s_a_stb = 1'b0, u_a_stb = 1'b0, s_z_ack = 1'b0, u_z_ack = 1'b0;
  logic s_ack, u_ack, s_stb, u_stb;
  logic [31:0] s_z, u_z;
  int checks = 0;
  int errors = 0;
  typedef struct {
    bit u;
    logic [31:0] a;
    logic [31:0] z;
    int lat;
    string name;
  } vec_t;
  vec_t v[12];
  always #5 clk = ~clk;
  int_to_float #(.SIGNED_IN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_a(s_a), .in_a_stb(s_a_stb), .in_a_ack(s_ack),
    .out_z(s_z), .out_z_stb(s_stb), .out_z_ack(s_z_ack)
  );
  int_to_float #(.SIGNED_IN(1'b0)) dut_u (
    .clk(clk), .rst(rst), .in_a(u_a), .in_a_stb(u_a_stb), .in_a_ack(u_ack),
    .out_z(u_z), .out_z_stb(u_stb), .out_z_ack(u_z_ack)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    chk("ack_stb_exclusive", {30'd0, s_ack & s_stb, u_ack & u_stb}, 32'd0);
  end
  function automatic logic ack_of(bit u);
    return u ? u_ack : s_ack;
  endfunction
  function automatic logic stb_of(bit u);
    return u ? u_stb : s_stb;
  endfunction
  function automatic logic [31:0] z_of(bit u);
    return u ? u_z : s_z;
  endfunction
  task automatic drive(bit u, logic [31:0] a, logic stb);
    if (u) begin
      u_a = a;
      u_a_stb = stb;
    end else begin
      s_a = a;
      s_a_stb = stb;
    end
  endtask
  task automatic zack(bit u, logic val);
    if (u) u_z_ack = val;
    else s_z_ack = val;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ack(bit u, string name);
    int n = 0;
    while (!ack_of(u) && n < 100) begin
      step;
      n++;
    end
    chk({name, " in_a_ack"}, {31'd0, ack_of(u)}, 32'd1);
  endtask
  task automatic wait_stb(bit u, output int n);
    n = 0;
    while (!stb_of(u) && n < 60) begin
      step;
      n++;
    end
  endtask
  task automatic take_z(bit u, string name);
    zack(u, 1'b1);
    step;
    zack(u, 1'b0);
    chk({name, " stb_drop"}, {31'd0, stb_of(u)}, 32'd0);
  endtask
  task automatic convert(bit u, logic [31:0] a, logic [31:0] z, int lat, string name);
    int n;
    wait_ack(u, name);
    drive(u, a, 1'b1);
    step;
    drive(u, a, 1'b0);
    chk({name, " ack_low"}, {31'd0, ack_of(u)}, 32'd0);
    wait_stb(u, n);
    chk({name, " latency"}, 32'(n), 32'(lat));
    chk({name, " out_z"}, z_of(u), z);
    take_z(u, name);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
  initial begin
    int n;
    bit saw;
    v[0]  = '{1'b0, 32'd1,        32'h3F800000, 35, "one"};
    v[1]  = '{1'b0, 32'hFFFFFFFF, 32'hBF800000, 35, "minus_one"};
    v[2]  = '{1'b0, 32'd0,        32'h00000000, 1,  "zero"};
    v[3]  = '{1'b0, 32'h80000000, 32'hCF000000, 4,  "min_int"};
    v[4]  = '{1'b0, 32'h7FFFFFFF, 32'h4F000000, 5,  "max_int_carry"};
    v[5]  = '{1'b0, 32'd16777217, 32'h4B800000, 11, "tie_even_down"};
    v[6]  = '{1'b0, 32'd16777219, 32'h4B800002, 11, "tie_up"};
    v[7]  = '{1'b0, 32'd16777221, 32'h4B800002, 11, "tie_even_down2"};
    v[8]  = '{1'b0, 32'd100,      32'h42C80000, 29, "hundred"};
    v[9]  = '{1'b0, 32'hFFFFFF9C, 32'hC2C80000, 29, "minus_hundred"};
    v[10] = '{1'b1, 32'hFFFFFFFF, 32'h4F800000, 4,  "unsigned_max"};
    v[11] = '{1'b1, 32'h80000000, 32'h4F000000, 4,  "unsigned_2p31"};
    repeat (3) step;
    chk("reset in_a_ack", {31'd0, s_ack}, 32'd0);
    chk("reset out_z_stb", {31'd0, s_stb}, 32'd0);
    chk("reset out_z", s_z, 32'd0);
    chk("reset u in_a_ack", {31'd0, u_ack}, 32'd0);
    rst = 1'b0;
    step;
    chk("first ack", {30'd0, s_ack, u_ack}, 32'd3);
    for (int i = 0; i < 12; i++) convert(v[i].u, v[i].a, v[i].z, v[i].lat, v[i].name);
    wait_ack(1'b0, "bp");
    drive(1'b0, 32'd100, 1'b1);
    step;
    drive(1'b0, 32'd3, 1'b1);
    chk("bp ack_low", {31'd0, s_ack}, 32'd0);
    wait_stb(1'b0, n);
    chk("bp latency", 32'(n), 32'd29);
    for (int i = 0; i < 10; i++) begin
      chk("bp out_z stable", s_z, 32'h42C80000);
      chk("bp hold", {30'd0, s_stb, s_ack}, 32'd2);
      step;
    end
    take_z(1'b0, "bp");
    wait_ack(1'b0, "bp second");
    step;
    drive(1'b0, 32'd0, 1'b0);
    wait_stb(1'b0, n);
    chk("bp second latency", 32'(n), 32'd34);
    chk("bp second out_z", s_z, 32'h40400000);
    take_z(1'b0, "bp second");
    wait_ack(1'b0, "rst_mid");
    drive(1'b0, 32'd1, 1'b1);
    step;
    drive(1'b0, 32'd0, 1'b0);
    repeat (10) step;
    rst = 1'b1;
    step;
    chk("rst_mid out_z", s_z, 32'd0);
    chk("rst_mid ack_stb", {30'd0, s_ack, s_stb}, 32'd0);
    rst = 1'b0;
    step;
    chk("rst_mid ack_back", {31'd0, s_ack}, 32'd1);
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      saw |= s_stb;
      step;
    end
    chk("rst_mid no_spurious_stb", {31'd0, saw}, 32'd0);
    convert(1'b0, 32'd3, 32'h40400000, 34, "three_after_rst");
    convert(1'b1, 32'hFFFFFFFF, 32'h4F800000, 4, "unsigned_max_again");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
